enigma_lamp_decoder: RTL



---
 rtl/enigma_lamp_decoder_if.sv | 38 +++
 rtl/enigma_lamp_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/enigma_lamp_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : enigma_lamp_decoder_if                                 |
// | Description : Key/lamp inputs, output character stream and error     |
// |               flags of the lamp decoder, bundled as one interface.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface enigma_lamp_decoder_if #(
  parameter int FIFO_DEPTH = 4
) ();
  logic                          key_strobe;
  logic [25:0]                   key_onehot;
  logic [25:0]                   lamp_in;
  logic                          busy;
  logic                          out_valid;
  logic                          out_ready;
  logic [7:0]                    out_char;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          err_key;
  logic                          err_lamp;
  logic                          err_self;
  logic [7:0]                    err_count;

  // Driver side: keyboard, lampboard and the downstream consumer
  modport master (
    output key_strobe, key_onehot, lamp_in, out_ready,
    input  busy, out_valid, out_char, fifo_level,
    input  err_key, err_lamp, err_self, err_count
  );

  // Decoder side
  modport slave (
    input  key_strobe, key_onehot, lamp_in, out_ready,
    output busy, out_valid, out_char, fifo_level,
    output err_key, err_lamp, err_self, err_count
  );
endinterface
`default_nettype wire

// File: rtl/enigma_lamp_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : enigma_lamp_decoder                                    |
// | Description : Waits for the rotor chain to settle after a keypress,  |
// |               samples and validates the lampboard, encodes the lit   |
// |               lamp to ASCII and queues it in a FWFT output FIFO.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module enigma_lamp_decoder #(
  parameter int         SETTLE_CYCLES = 4,
  parameter int         FIFO_DEPTH    = 4,
  parameter logic [7:0] ERR_CHAR      = 8'h3F
) (
  input  logic                  clk,
  input  logic                  reset_n,
  enigma_lamp_decoder_if.slave  bus
);

  localparam int                 c_PTR_W       = $clog2(FIFO_DEPTH);
  localparam int                 c_LVL_W       = c_PTR_W + 1;
  localparam logic [c_LVL_W-1:0] c_DEPTH       = c_LVL_W'(FIFO_DEPTH);
  localparam logic [3:0]         c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    PUSH   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic [4:0]           r_key_idx;
  logic [4:0]           w_key_idx_nxt;
  logic [7:0]           r_result;
  logic [7:0]           w_result_nxt;
  logic                 w_err_key_nxt;
  logic                 w_err_lamp_nxt;
  logic                 w_err_self_nxt;
  logic                 w_push;
  logic                 w_pop;

  logic                 r_err_key;
  logic                 r_err_lamp;
  logic                 r_err_self;
  logic [7:0]           r_err_count;

  logic [4:0]           w_key_cnt;
  logic [4:0]           w_key_idx;
  logic [4:0]           w_lamp_cnt;
  logic [4:0]           w_lamp_idx;

  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_LVL_W-1:0]   r_level;

  // Popcount and index of the pressed key and of the lit lamp
  always_comb begin
    w_key_cnt  = '0;
    w_key_idx  = '0;
    w_lamp_cnt = '0;
    w_lamp_idx = '0;
    for (int i = 0; i < 26; i++) begin
      if (bus.key_onehot[i]) begin
        w_key_cnt = w_key_cnt + 5'd1;
        w_key_idx = 5'(i);
      end
      if (bus.lamp_in[i]) begin
        w_lamp_cnt = w_lamp_cnt + 5'd1;
        w_lamp_idx = 5'(i);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state, datapath loads, error detection and push request
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_key_idx_nxt  = r_key_idx;
    w_result_nxt   = r_result;
    w_err_key_nxt  = 1'b0;
    w_err_lamp_nxt = 1'b0;
    w_err_self_nxt = 1'b0;
    w_push         = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.key_strobe) begin
          if (w_key_cnt == 5'd1) begin
            w_key_idx_nxt = w_key_idx;
            w_cnt_nxt     = c_SETTLE_LOAD;
            w_state_nxt   = SETTLE;
          end else begin
            w_err_key_nxt = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (r_cnt == 4'd0) w_state_nxt = CHECK;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      CHECK: begin
        if (w_lamp_cnt != 5'd1) begin
          w_result_nxt   = ERR_CHAR;
          w_err_lamp_nxt = 1'b1;
        end else if (w_lamp_idx == r_key_idx) begin
          w_result_nxt   = ERR_CHAR;
          w_err_self_nxt = 1'b1;
        end else begin
          w_result_nxt   = 8'h41 + {3'b000, w_lamp_idx};
        end
        w_state_nxt = PUSH;
      end
      PUSH: begin
        // Space is judged on the registered level only: a pop in the same
        // cycle does not open a slot until the next cycle.
        if (r_level < c_DEPTH) begin
          w_push      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath registers, one-cycle error pulses and saturating error count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_key_idx   <= '0;
      r_result    <= '0;
      r_err_key   <= 1'b0;
      r_err_lamp  <= 1'b0;
      r_err_self  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_key_idx   <= w_key_idx_nxt;
      r_result    <= w_result_nxt;
      r_err_key   <= w_err_key_nxt;
      r_err_lamp  <= w_err_lamp_nxt;
      r_err_self  <= w_err_self_nxt;
      if ((w_err_key_nxt || w_err_lamp_nxt || w_err_self_nxt) && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
    end
  end

  assign w_pop = (r_level != '0) && bus.out_ready;

  // FIFO storage; contents are don't-care while the level says empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_result;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.busy       = (r_state != IDLE);
  assign bus.out_valid  = (r_level != '0);
  assign bus.out_char   = (r_level != '0) ? r_mem[r_rd_ptr] : 8'h00;
  assign bus.fifo_level = r_level;
  assign bus.err_key    = r_err_key;
  assign bus.err_lamp   = r_err_lamp;
  assign bus.err_self   = r_err_self;
  assign bus.err_count  = r_err_count;

endmodule
`default_nettype wire
